atom_seq_ctrl: RTL and testbench

Sequencing and configuration controller for the single-state if/else stateful atom, one 32-bit state register updated every clock. It accepts packets through a valid/ready interface and issues at most one per cycle to the atom. On idle cycles it drives a "hold" configuration so the atom state is preserved. It also loads the atom's selector and constant fields through a shadow/active register pair with atomic commit, and returns the pre- and post-update state for each issued packet.

---
 rtl/atom_seq_pkg.sv | 63 ++++++
 rtl/atom_seq_cfg_regs.sv | 61 ++++++
 rtl/atom_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_atom_seq_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atom_seq_pkg.sv
// atom_seq_pkg: shared types, register map and HOLD config for the atom sequencer.
// INIT support is compiled in only when ATOM_SEQ_INIT_EN is defined.
package atom_seq_pkg;

    typedef logic [31:0] int32_t;
    typedef logic [1:0]  int2_t;
    typedef logic        bool;

    localparam logic [3:0] ADDR_CONS_1 = 4'd0;
    localparam logic [3:0] ADDR_CONS_2 = 4'd1;
    localparam logic [3:0] ADDR_CONS_3 = 4'd2;
    localparam logic [3:0] ADDR_SEL    = 4'd3;
    localparam logic [3:0] ADDR_COMMIT = 4'd4;
    localparam logic [3:0] ADDR_ENABLE = 4'd5;
`ifdef ATOM_SEQ_INIT_EN
    localparam logic [3:0] ADDR_INIT   = 4'd6;
`endif

    localparam int SEL_W = 11;

    // Field offsets: packed from bit 0 upward
    typedef struct packed {
        int2_t rel_opcode; // [10:9]
        int2_t sel_6;      // [8:7]
        bool   sel_5;      // [6]
        int2_t sel_4;      // [5:4]
        bool   sel_3;      // [3]
        int2_t sel_2;      // [2:1]
        bool   sel_1;      // [0]
    } sel_t;

    typedef struct packed {
        int32_t cons_1;
        int32_t cons_2;
        int32_t cons_3;
        sel_t   sel;
    } atom_cfg_t;

    // Both branches add cons (=0) to the unmasked state: state is preserved
    localparam sel_t SEL_HOLD = '{
        rel_opcode: 2'd0, sel_6: 2'd2, sel_5: 1'b0, sel_4: 2'd2,
        sel_3: 1'b0, sel_2: 2'd0, sel_1: 1'b0
    };

    localparam atom_cfg_t CFG_HOLD = '{
        cons_1: 32'd0, cons_2: 32'd0, cons_3: 32'd0, sel: SEL_HOLD
    };

`ifdef ATOM_SEQ_INIT_EN
    // Both branches mask the state and add cons: state becomes cons
    localparam sel_t SEL_INIT = '{
        rel_opcode: 2'd0, sel_6: 2'd2, sel_5: 1'b1, sel_4: 2'd2,
        sel_3: 1'b1, sel_2: 2'd0, sel_1: 1'b0
    };
`endif

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_COMMIT = 2'd1,
        ST_INIT   = 2'd2
    } state_e;

endpackage

// File: rtl/atom_seq_cfg_regs.sv
// atom_seq_cfg_regs: shadow/active atom configuration with atomic commit.
// Writes land in shadow only; active copies shadow on the commit strobe.
module atom_seq_cfg_regs
    import atom_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [3:0]       wr_addr_i,
    input  logic [31:0]      wr_data_i,
    input  logic             commit_i,
    output logic [31:0]      cons_1_o,
    output logic [31:0]      cons_2_o,
    output logic [31:0]      cons_3_o,
    output logic [SEL_W-1:0] sel_o
);

    atom_cfg_t shadow_q;
    atom_cfg_t shadow_d;
    atom_cfg_t active_q;
    atom_cfg_t active_d;

    // Decode register-map writes into the shadow copy
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            unique case (wr_addr_i)
                ADDR_CONS_1: shadow_d.cons_1 = wr_data_i;
                ADDR_CONS_2: shadow_d.cons_2 = wr_data_i;
                ADDR_CONS_3: shadow_d.cons_3 = wr_data_i;
                ADDR_SEL:    shadow_d.sel    = sel_t'(wr_data_i[SEL_W-1:0]);
                default:     shadow_d = shadow_q;
            endcase
        end
    end

    // Active config only moves on commit
    always_comb begin
        active_d = active_q;
        if (commit_i) begin
            active_d = shadow_q;
        end
    end

    // Both copies come out of reset as HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= CFG_HOLD;
            active_q <= CFG_HOLD;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign cons_1_o = active_q.cons_1;
    assign cons_2_o = active_q.cons_2;
    assign cons_3_o = active_q.cons_3;
    assign sel_o    = active_q.sel;

endmodule

// File: rtl/atom_seq_ctrl.sv
// atom_seq_ctrl: packet issue, HOLD on idle, config commit and result capture.
// Define ATOM_SEQ_INIT_EN to enable the INIT register and INIT state.
module atom_seq_ctrl
    import atom_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        pkt_in_valid,
    output logic        pkt_in_ready,
    input  logic [31:0] pkt_in_1,
    input  logic [31:0] pkt_in_2,
    output logic [31:0] atom_pkt_1,
    output logic [31:0] atom_pkt_2,
    output logic [31:0] atom_cons_1,
    output logic [31:0] atom_cons_2,
    output logic [31:0] atom_cons_3,
    output logic        atom_sel_1,
    output logic        atom_sel_3,
    output logic        atom_sel_5,
    output logic [1:0]  atom_sel_2,
    output logic [1:0]  atom_sel_4,
    output logic [1:0]  atom_sel_6,
    output logic [1:0]  atom_rel_opcode,
    input  logic [31:0] atom_read,
    input  logic [31:0] atom_write,
    output logic        res_valid,
    output logic [31:0] res_old,
    output logic [31:0] res_new,
    output logic [31:0] pkt_count
);

    state_e      state_q;
    logic        cfg_ready_q;
    logic        pkt_ready_q;
    logic        enable_q;
    logic        enable_d;
    logic        res_valid_q;
    logic [31:0] res_old_q;
    logic [31:0] res_new_q;
    logic [31:0] pkt_count_q;

    logic             cfg_fire;
    logic             issue;
    logic             commit;
    logic [31:0]      act_cons_1;
    logic [31:0]      act_cons_2;
    logic [31:0]      act_cons_3;
    logic [SEL_W-1:0] act_sel;
    atom_cfg_t        active_cfg;
    atom_cfg_t        drv_cfg;
    logic [31:0]      drv_pkt_1;
    logic [31:0]      drv_pkt_2;

    assign cfg_fire = cfg_valid & cfg_ready_q;
    assign issue    = pkt_in_valid & pkt_ready_q;
    assign commit   = (state_q == ST_COMMIT);

    atom_seq_cfg_regs u_cfg_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (cfg_fire),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .commit_i  (commit),
        .cons_1_o  (act_cons_1),
        .cons_2_o  (act_cons_2),
        .cons_3_o  (act_cons_3),
        .sel_o     (act_sel)
    );

    assign active_cfg = '{
        cons_1: act_cons_1,
        cons_2: act_cons_2,
        cons_3: act_cons_3,
        sel:    sel_t'(act_sel)
    };

`ifdef ATOM_SEQ_INIT_EN
    logic [31:0] init_q;

    // INIT value is captured with the write that starts INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 32'd0;
        end else if (cfg_fire && cfg_addr == ADDR_INIT) begin
            init_q <= cfg_data;
        end
    end
`endif

    // ENABLE as it will be after this cycle's write, so ready tracks it next cycle
    always_comb begin
        enable_d = enable_q;
        if (cfg_fire && cfg_addr == ADDR_ENABLE) begin
            enable_d = cfg_data[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable_d;
        end
    end

    // Sequencer FSM; both ready outputs are registered with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cfg_ready_q <= 1'b0;
            pkt_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (cfg_fire && cfg_addr == ADDR_COMMIT) begin
                        state_q     <= ST_COMMIT;
                        cfg_ready_q <= 1'b0;
                        pkt_ready_q <= 1'b0;
`ifdef ATOM_SEQ_INIT_EN
                    end else if (cfg_fire && cfg_addr == ADDR_INIT) begin
                        state_q     <= ST_INIT;
                        cfg_ready_q <= 1'b0;
                        pkt_ready_q <= 1'b0;
`endif
                    end else begin
                        state_q     <= ST_RUN;
                        cfg_ready_q <= 1'b1;
                        pkt_ready_q <= enable_d;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    cfg_ready_q <= 1'b1;
                    pkt_ready_q <= enable_d;
                end
            endcase
        end
    end

    // Atom drive: active config on issue, INIT override, HOLD otherwise
    always_comb begin
        drv_cfg   = CFG_HOLD;
        drv_pkt_1 = 32'd0;
        drv_pkt_2 = 32'd0;
        if (issue) begin
            drv_cfg   = active_cfg;
            drv_pkt_1 = pkt_in_1;
            drv_pkt_2 = pkt_in_2;
        end
`ifdef ATOM_SEQ_INIT_EN
        if (state_q == ST_INIT) begin
            drv_cfg.sel    = SEL_INIT;
            drv_cfg.cons_2 = init_q;
            drv_cfg.cons_3 = init_q;
        end
`endif
    end

    assign atom_pkt_1      = drv_pkt_1;
    assign atom_pkt_2      = drv_pkt_2;
    assign atom_cons_1     = drv_cfg.cons_1;
    assign atom_cons_2     = drv_cfg.cons_2;
    assign atom_cons_3     = drv_cfg.cons_3;
    assign atom_sel_1      = drv_cfg.sel.sel_1;
    assign atom_sel_2      = drv_cfg.sel.sel_2;
    assign atom_sel_3      = drv_cfg.sel.sel_3;
    assign atom_sel_4      = drv_cfg.sel.sel_4;
    assign atom_sel_5      = drv_cfg.sel.sel_5;
    assign atom_sel_6      = drv_cfg.sel.sel_6;
    assign atom_rel_opcode = drv_cfg.sel.rel_opcode;

    // Capture pre/post state of each issued packet and count it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_old_q   <= 32'd0;
            res_new_q   <= 32'd0;
            pkt_count_q <= 32'd0;
        end else begin
            res_valid_q <= issue;
            if (issue) begin
                res_old_q   <= atom_read;
                res_new_q   <= atom_write;
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign pkt_in_ready = pkt_ready_q;
    assign res_valid    = res_valid_q;
    assign res_old      = res_old_q;
    assign res_new      = res_new_q;
    assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_atom_seq_ctrl.sv
// tb_atom_seq_ctrl: scoreboard bench with a behavioural if/else stateful atom.
// Builds with or without ATOM_SEQ_INIT_EN; state is seeded by INIT or by a load packet.
module tb_atom_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_addr = 4'd0;
    logic [31:0] cfg_data = 32'd0;
    logic        pkt_in_valid = 1'b0;
    logic        pkt_in_ready;
    logic [31:0] pkt_in_1 = 32'd0;
    logic [31:0] pkt_in_2 = 32'd0;
    logic [31:0] atom_pkt_1, atom_pkt_2;
    logic [31:0] atom_cons_1, atom_cons_2, atom_cons_3;
    logic        atom_sel_1, atom_sel_3, atom_sel_5;
    logic [1:0]  atom_sel_2, atom_sel_4, atom_sel_6, atom_rel_opcode;
    logic [31:0] atom_read, atom_write;
    logic        res_valid;
    logic [31:0] res_old, res_new, pkt_count;

    typedef struct {
        logic [31:0] old_v;
        logic [31:0] new_v;
        bit          chk_old;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_cnt = 32'd0;

    always #5 clk = ~clk;

    atom_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
        .pkt_in_1(pkt_in_1), .pkt_in_2(pkt_in_2),
        .atom_pkt_1(atom_pkt_1), .atom_pkt_2(atom_pkt_2),
        .atom_cons_1(atom_cons_1), .atom_cons_2(atom_cons_2),
        .atom_cons_3(atom_cons_3),
        .atom_sel_1(atom_sel_1), .atom_sel_3(atom_sel_3),
        .atom_sel_5(atom_sel_5), .atom_sel_2(atom_sel_2),
        .atom_sel_4(atom_sel_4), .atom_sel_6(atom_sel_6),
        .atom_rel_opcode(atom_rel_opcode),
        .atom_read(atom_read), .atom_write(atom_write),
        .res_valid(res_valid), .res_old(res_old), .res_new(res_new),
        .pkt_count(pkt_count)
    );

    // Behavioural atom: if (rel(opt(s), mux3)) s = opt(s)+mux3 else s = opt(s)+mux3
    function automatic logic [31:0] mux3(input logic [1:0] s,
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            default: return c;
        endcase
    endfunction

    logic [31:0] atom_state;
    logic [31:0] a_lhs, a_rhs, a_then, a_else;
    logic        a_cond;

    assign atom_read = atom_state;
    assign a_lhs  = atom_sel_1 ? 32'd0 : atom_state;
    assign a_rhs  = mux3(atom_sel_2, atom_pkt_1, atom_pkt_2, atom_cons_1);
    assign a_then = (atom_sel_3 ? 32'd0 : atom_state) + mux3(atom_sel_4, atom_pkt_1, atom_pkt_2, atom_cons_2);
    assign a_else = (atom_sel_5 ? 32'd0 : atom_state) + mux3(atom_sel_6, atom_pkt_1, atom_pkt_2, atom_cons_3);

    always_comb begin
        a_cond = 1'b0;
        case (atom_rel_opcode)
            2'd0:    a_cond = (a_lhs != a_rhs);
            2'd1:    a_cond = (a_lhs < a_rhs);
            2'd2:    a_cond = (a_lhs > a_rhs);
            default: a_cond = (a_lhs == a_rhs);
        endcase
    end

    assign atom_write = a_cond ? a_then : a_else;

    always @(posedge clk) atom_state <= atom_write;

    // Scoreboard: one expected entry per accepted packet, popped on res_valid
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL res_unexpected res_valid=1 with empty scoreboard, res_new=%h", res_new);
            end else begin
                e = sb.pop_front();
                if (res_new !== e.new_v) begin
                    miscompares++;
                    $display("FAIL res_new got %h want %h", res_new, e.new_v);
                end
                if (e.chk_old) begin
                    vectors++;
                    if (res_old !== e.old_v) begin
                        miscompares++;
                        $display("FAIL res_old got %h want %h", res_old, e.old_v);
                    end
                end
            end
        end
    end

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        while (!cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL cfg_timeout addr %0d cfg_ready got %b want 1", a, cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] p1, input logic [31:0] p2,
        input logic [31:0] old_v, input logic [31:0] new_v, input bit chk_old);
        int n = 0;
        pkt_in_valid = 1'b1;
        pkt_in_1     = p1;
        pkt_in_2     = p2;
        while (!pkt_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!pkt_in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL pkt_timeout pkt_in_ready got %b want 1", pkt_in_ready);
        end else begin
            sb.push_back('{old_v: old_v, new_v: new_v, chk_old: chk_old});
            exp_cnt = exp_cnt + 32'd1;
        end
        @(negedge clk);
        pkt_in_valid = 1'b0;
        pkt_in_1     = 32'd0;
        pkt_in_2     = 32'd0;
    endtask

    task automatic set_state(input logic [31:0] v);
`ifdef ATOM_SEQ_INIT_EN
        cfg_write(4'd6, v);
        vectors++;
        if (cfg_ready !== 1'b0 || pkt_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL init_ready got cfg %b pkt %b want 0 0", cfg_ready, pkt_in_ready);
        end
        vectors++;
        if (atom_sel_3 !== 1'b1 || atom_sel_5 !== 1'b1 || atom_cons_2 !== v || atom_cons_3 !== v) begin
            miscompares++;
            $display("FAIL init_drive got sel3 %b sel5 %b c2 %h c3 %h want 1 1 %h %h",
                     atom_sel_3, atom_sel_5, atom_cons_2, atom_cons_3, v, v);
        end
        @(negedge clk);
`else
        cfg_write(4'd5, 32'd1);
        cfg_write(4'd3, 32'h48);
        cfg_write(4'd4, 32'd0);
        send_pkt(v, 32'd0, 32'd0, v, 1'b0);
        @(negedge clk);
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (cfg_ready !== 1'b0 || pkt_in_ready !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl got cfg %b pkt %b rv %b want 0 0 0", cfg_ready, pkt_in_ready, res_valid);
        end
        vectors++;
        if (res_old !== 32'd0 || res_new !== 32'd0 || pkt_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_res got old %h new %h cnt %h want 0 0 0", res_old, res_new, pkt_count);
        end
        vectors++;
        if (atom_sel_4 !== 2'd2 || atom_sel_6 !== 2'd2 || atom_sel_3 !== 1'b0 || atom_cons_2 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_hold got sel4 %0d sel6 %0d sel3 %b c2 %h want 2 2 0 0",
                     atom_sel_4, atom_sel_6, atom_sel_3, atom_cons_2);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (cfg_ready !== 1'b1 || pkt_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_run got cfg %b pkt %b want 1 0", cfg_ready, pkt_in_ready);
        end
    endtask

    task automatic test_hold;
        set_state(32'd5);
        cfg_write(4'd5, 32'd1);
        repeat (10) @(negedge clk);
        vectors++;
        if (atom_read !== 32'd5) begin
            miscompares++;
            $display("FAIL hold_state got %h want 5", atom_read);
        end
        vectors++;
        if (pkt_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL hold_count got %h want %h", pkt_count, exp_cnt);
        end
        vectors++;
        if (atom_sel_4 !== 2'd2 || atom_sel_6 !== 2'd2 || atom_sel_5 !== 1'b0 ||
            atom_cons_3 !== 32'd0 || atom_pkt_1 !== 32'd0 || pkt_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_drive got sel4 %0d sel6 %0d sel5 %b c3 %h p1 %h rdy %b want 2 2 0 0 0 1",
                     atom_sel_4, atom_sel_6, atom_sel_5, atom_cons_3, atom_pkt_1, pkt_in_ready);
        end
    endtask

    task automatic test_counter;
        cfg_write(4'd3, 32'd0);
        cfg_write(4'd4, 32'd0);
        send_pkt(32'd3, 32'd0, 32'd5, 32'd8, 1'b1);
        send_pkt(32'd3, 32'd0, 32'd8, 32'd11, 1'b1);
        send_pkt(32'd3, 32'd0, 32'd11, 32'd14, 1'b1);
        @(negedge clk);
        vectors++;
        if (atom_read !== 32'd14 || pkt_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL counter_end got state %h cnt %h want 14 %h", atom_read, pkt_count, exp_cnt);
        end
    endtask

    task automatic test_commit_order;
        cfg_write(4'd3, 32'h90);
        cfg_valid    = 1'b1;
        cfg_addr     = 4'd4;
        cfg_data     = 32'd0;
        pkt_in_valid = 1'b1;
        pkt_in_1     = 32'd2;
        pkt_in_2     = 32'd100;
        vectors++;
        if (cfg_ready !== 1'b1 || pkt_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL order_ready got cfg %b pkt %b want 1 1", cfg_ready, pkt_in_ready);
        end
        sb.push_back('{old_v: 32'd14, new_v: 32'd16, chk_old: 1'b1});
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (pkt_in_ready !== 1'b0 || cfg_ready !== 1'b0 || atom_sel_4 !== 2'd2 || atom_pkt_2 !== 32'd0) begin
            miscompares++;
            $display("FAIL order_bubble got pkt %b cfg %b sel4 %0d p2 %h want 0 0 2 0",
                     pkt_in_ready, cfg_ready, atom_sel_4, atom_pkt_2);
        end
        @(negedge clk);
        vectors++;
        if (pkt_in_ready !== 1'b1 || atom_sel_4 !== 2'd1 || atom_sel_6 !== 2'd1) begin
            miscompares++;
            $display("FAIL order_newcfg got pkt %b sel4 %0d sel6 %0d want 1 1 1",
                     pkt_in_ready, atom_sel_4, atom_sel_6);
        end
        cfg_valid = 1'b1;
        cfg_addr  = 4'd3;
        cfg_data  = 32'd0;
        sb.push_back('{old_v: 32'd16, new_v: 32'd116, chk_old: 1'b1});
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        cfg_valid    = 1'b0;
        pkt_in_valid = 1'b0;
        pkt_in_1     = 32'd0;
        pkt_in_2     = 32'd0;
        @(negedge clk);
        vectors++;
        if (atom_read !== 32'd116 || pkt_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL order_end got state %h cnt %h want 116 %h", atom_read, pkt_count, exp_cnt);
        end
    endtask

    task automatic test_disabled;
        cfg_write(4'd5, 32'd0);
        vectors++;
        if (pkt_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL dis_ready got %b want 0", pkt_in_ready);
        end
        pkt_in_valid = 1'b1;
        pkt_in_1     = 32'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (pkt_in_ready !== 1'b0 || res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL dis_cycle%0d got rdy %b rv %b want 0 0", i, pkt_in_ready, res_valid);
            end
        end
        cfg_write(4'd3, 32'd0);
        pkt_in_valid = 1'b0;
        pkt_in_1     = 32'd0;
        vectors++;
        if (atom_read !== 32'd116 || pkt_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL dis_end got state %h cnt %h want 116 %h", atom_read, pkt_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_commit;
        cfg_write(4'd5, 32'd1);
        cfg_write(4'd0, 32'h1234);
        cfg_valid = 1'b1;
        cfg_addr  = 4'd4;
        cfg_data  = 32'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        exp_cnt = 32'd0;
        vectors++;
        if (cfg_ready !== 1'b0 || pkt_in_ready !== 1'b0 || res_valid !== 1'b0 ||
            res_old !== 32'd0 || res_new !== 32'd0 || pkt_count !== 32'd0) begin
            miscompares++;
            $display("FAIL midrst_out got cfg %b pkt %b rv %b old %h new %h cnt %h want all 0",
                     cfg_ready, pkt_in_ready, res_valid, res_old, res_new, pkt_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cfg_write(4'd5, 32'd1);
        vectors++;
        if (atom_cons_1 !== 32'd0 || atom_sel_4 !== 2'd2) begin
            miscompares++;
            $display("FAIL midrst_idle got c1 %h sel4 %0d want 0 2", atom_cons_1, atom_sel_4);
        end
        send_pkt(32'd9, 32'd9, 32'd116, 32'd116, 1'b1);
        @(negedge clk);
        vectors++;
        if (atom_read !== 32'd116 || pkt_count !== 32'd1) begin
            miscompares++;
            $display("FAIL midrst_end got state %h cnt %h want 116 1", atom_read, pkt_count);
        end
    endtask

    task automatic test_wrap;
        set_state(32'hFFFF_FFFF);
        cfg_write(4'd3, 32'd0);
        cfg_write(4'd4, 32'd0);
        send_pkt(32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        @(negedge clk);
        vectors++;
        if (atom_read !== 32'd0) begin
            miscompares++;
            $display("FAIL wrap_state got %h want 0", atom_read);
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_counter();
        test_commit_order();
        test_disabled();
        test_reset_mid_commit();
        test_wrap();
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
